ts_measure_arbiter: RTL and testbench

- Shares the single measurement engine (measure_start / measure_ready / measure_done) among NUM_REQ trigger-subsystem cores.
- Grants requesters round-robin and latches the RTC timestamp at each start.
- Returns a done or timeout pulse to the owning requester.
- Sits between the axi_ts_core instances and the device measurement logic.

---
 rtl/ts_arb_pkg.sv | 21 ++
 rtl/ts_rr_picker.sv | 31 +++
 rtl/ts_measure_arbiter.sv | 144 ++++++++++++++
 tb/tb_ts_measure_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_arb_pkg.sv
// Shared types and helpers for the measurement-engine arbiter.
// State encoding, owner-index width helper and the grant-counter width.
package ts_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam int STAT_CNT_W = 16;

  // Index width for n requesters, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ts_rr_picker.sv
// Round-robin pick of the first pending requester after last_grant, wrapping to 0.
// Purely combinational; valid is low when nothing is pending.
module ts_rr_picker
  import ts_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  int cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!valid && pending[IDX_W'(cand)]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ts_measure_arbiter.sv
// Round-robin share of one measurement engine among NUM_REQ cores, RTC stamped at each start;
// req_start to measure_start >= 2 cycles; engine backpressure via measure_ready. TS_ARB_STATS_EN adds grant counters.
module ts_measure_arbiter
  import ts_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 24
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NUM_REQ-1:0]             req_start,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [NUM_REQ-1:0]             req_timeout,
  output logic                           measure_start,
  input  logic                           measure_ready,
  input  logic                           measure_done,
  input  logic [31:0]                    rtc_sec,
  input  logic [31:0]                    rtc_nsec,
  input  logic [TIMEOUT_W-1:0]           cfg_timeout,
  output logic                           stat_busy,
  output logic [clog2_min1(NUM_REQ)-1:0] stat_owner,
  output logic [31:0]                    ts_sec,
  output logic [31:0]                    ts_nsec
`ifdef TS_ARB_STATS_EN
  ,
  input  logic                           stat_clear,
  output logic [NUM_REQ*STAT_CNT_W-1:0]  stat_grant_cnt
`endif
);

  localparam int OW = clog2_min1(NUM_REQ);

  arb_state_t           state, state_nxt;
  logic [NUM_REQ-1:0]   pending;
  logic [OW-1:0]        last_grant;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 pick_vld;
  logic [OW-1:0]        pick_idx;
  logic                 grant_fire, done_fire, timeout_fire, wd_hit;
  logic [NUM_REQ-1:0]   owner_mask, grant_mask, accept;

  ts_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_picker (
    .pending    (pending),
    .last_grant (last_grant),
    .valid      (pick_vld),
    .index      (pick_idx)
  );

  assign owner_mask    = NUM_REQ'(1) << stat_owner;
  assign grant_mask    = NUM_REQ'(1) << pick_idx;
  assign stat_busy     = (state != IDLE);
  assign measure_start = (state == START);
  // Decoded from registers only, so req_start never loops back into req_ready.
  assign req_ready     = ~pending & ~(stat_busy ? owner_mask : '0);
  assign accept        = req_start & req_ready;
  // Live compare: a cfg_timeout change mid-measurement applies at once.
  assign wd_hit        = (cfg_timeout != '0) && (wd_cnt == cfg_timeout - TIMEOUT_W'(1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    grant_fire   = 1'b0;
    done_fire    = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld && measure_ready) begin
          grant_fire = 1'b1;
          state_nxt  = START;
        end
      end
      START: state_nxt = BUSY;
      BUSY: begin
        // Done takes priority over a watchdog hit in the same cycle.
        if (measure_done) begin
          done_fire = 1'b1;
          state_nxt = IDLE;
        end else if (wd_hit) begin
          timeout_fire = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pending     <= '0;
      last_grant  <= OW'(NUM_REQ - 1);
      stat_owner  <= '0;
      wd_cnt      <= '0;
      ts_sec      <= '0;
      ts_nsec     <= '0;
      req_done    <= '0;
      req_timeout <= '0;
    end else begin
      pending     <= (pending | accept) & ~(grant_fire ? grant_mask : '0);
      req_done    <= done_fire    ? owner_mask : '0;
      req_timeout <= timeout_fire ? owner_mask : '0;
      if (grant_fire) begin
        stat_owner <= pick_idx;
        last_grant <= pick_idx;
      end
      if (state == START) begin
        ts_sec  <= rtc_sec;
        ts_nsec <= rtc_nsec;
        wd_cnt  <= '0;
      end else if (state == BUSY && wd_cnt != '1) begin
        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
      end
    end
  end

`ifdef TS_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
    logic [STAT_CNT_W-1:0] cnt;
    logic                  hit;

    assign hit = grant_fire && (pick_idx == OW'(g));

    // A grant coinciding with a clear counts as the first grant after it.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)        cnt <= '0;
      else if (hit)        cnt <= stat_clear ? STAT_CNT_W'(1)
                                 : (cnt == '1) ? cnt : cnt + STAT_CNT_W'(1);
      else if (stat_clear) cnt <= '0;
    end

    assign stat_grant_cnt[g*STAT_CNT_W +: STAT_CNT_W] = cnt;
  end
`else
  // Grant statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_ts_measure_arbiter.sv
// Randomized and directed stimulus for ts_measure_arbiter, checked each cycle
// against a session-level reference model (pending set, owner, age since grant).
`timescale 1ns/1ps
module tb_ts_measure_arbiter;

  localparam int N  = 4;
  localparam int TW = 24;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [N-1:0]  req_start = '0;
  logic [N-1:0]  req_ready, req_done, req_timeout;
  logic          measure_start, stat_busy;
  logic          measure_ready = 1'b0;
  logic          measure_done = 1'b0;
  logic [31:0]   rtc_sec = '0, rtc_nsec = '0;
  logic [TW-1:0] cfg_timeout = '0;
  logic [1:0]    stat_owner;
  logic [31:0]   ts_sec, ts_nsec;
`ifdef TS_ARB_STATS_EN
  logic          stat_clear = 1'b0;
  logic [N*16-1:0] stat_grant_cnt;
`endif

  ts_measure_arbiter #(.NUM_REQ(N), .TIMEOUT_W(TW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req_start     (req_start),
    .req_ready     (req_ready),
    .req_done      (req_done),
    .req_timeout   (req_timeout),
    .measure_start (measure_start),
    .measure_ready (measure_ready),
    .measure_done  (measure_done),
    .rtc_sec       (rtc_sec),
    .rtc_nsec      (rtc_nsec),
    .cfg_timeout   (cfg_timeout),
    .stat_busy     (stat_busy),
    .stat_owner    (stat_owner),
    .ts_sec        (ts_sec),
    .ts_nsec       (ts_nsec)
`ifdef TS_ARB_STATS_EN
    ,
    .stat_clear     (stat_clear),
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  // Reference model state
  logic [N-1:0] m_pend;
  int           m_last, m_owner, m_age;
  bit           m_active;
  logic [31:0]  m_ts_sec, m_ts_nsec;
  logic [N-1:0] m_done, m_to;
  int           m_cnt [N];

  int n_checks = 0;
  int n_errors = 0;

  // Observations
  int cyc = 0;
  int last_start_cyc = -1;
  int last_to_cyc = -1;
  int n_start_seen = 0, n_done_seen = 0, n_to_seen = 0;
  logic [N-1:0] rdy_at_done = '0;
  int start_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = ~m_pend;
    if (m_active) r[m_owner] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_last = N - 1; m_owner = 0; m_age = 0; m_active = 0;
    m_ts_sec = '0; m_ts_nsec = '0; m_done = '0; m_to = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic check_outputs();
    check_eq("req_ready",   64'(req_ready),   64'(exp_ready()));
    check_eq("req_done",    64'(req_done),    64'(m_done));
    check_eq("req_timeout", 64'(req_timeout), 64'(m_to));
    check_eq("measure_start", 64'(measure_start), 64'(m_active && m_age == 0));
    check_eq("stat_busy",   64'(stat_busy),   64'(m_active));
    check_eq("stat_owner",  64'(stat_owner),  64'(m_owner));
    check_eq("ts",          {ts_sec, ts_nsec}, {m_ts_sec, m_ts_nsec});
`ifdef TS_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      check_eq("grant_cnt", 64'(stat_grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
  endtask

  task automatic model_step(input logic [N-1:0] rs, input logic mr, input logic md,
                            input logic [TW-1:0] cfg, input logic clr);
    logic [N-1:0] nxt;
    int pick;
    nxt = m_pend | (rs & exp_ready());
    m_done = '0;
    m_to = '0;
    pick = -1;
    if (m_active) begin
      if (m_age == 0) begin
        m_ts_sec = rtc_sec; m_ts_nsec = rtc_nsec; m_age = 1;
      end else if (md) begin
        m_done[m_owner] = 1'b1; m_active = 0;
      end else if (cfg != 0 && m_age == int'(cfg)) begin
        m_to[m_owner] = 1'b1; m_active = 0;
      end else begin
        m_age++;
      end
    end else if (m_pend != 0 && mr) begin
      for (int k = 1; k <= N && pick < 0; k++)
        if (m_pend[(m_last + k) % N]) pick = (m_last + k) % N;
      nxt[pick] = 1'b0;
      m_last = pick; m_owner = pick; m_active = 1; m_age = 0;
    end
    if (clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    if (pick >= 0 && m_cnt[pick] < 65535) m_cnt[pick]++;
    m_pend = nxt;
  endtask

  task automatic tick(input logic [N-1:0] rs, input logic mr, input logic md, input logic [TW-1:0] cfg);
    logic clr;
    @(negedge aclk);
    cyc++;
    check_outputs();
    if (measure_start === 1'b1) begin
      last_start_cyc = cyc; n_start_seen++; start_q.push_back(int'(stat_owner));
    end
    if (|req_done) begin n_done_seen++; rdy_at_done = req_ready; end
    if (|req_timeout) begin n_to_seen++; last_to_cyc = cyc; end
    clr = 1'b0;
`ifdef TS_ARB_STATS_EN
    clr = ($urandom_range(0, 49) == 0);
    stat_clear = clr;
`endif
    req_start = rs; measure_ready = mr; measure_done = md; cfg_timeout = cfg;
    rtc_sec = $urandom; rtc_nsec = $urandom;
    model_step(rs, mr, md, cfg, clr);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    req_start = '0; measure_done = 1'b0;
`ifdef TS_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    model_reset();
    repeat (3) begin
      @(negedge aclk);
      check_outputs();
    end
    aresetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int req_cyc, d0, t0;
    logic [N-1:0] rs;
    logic [TW-1:0] cfg;

    model_reset();
    do_reset();
    repeat (3) tick('0, 1'b1, 1'b0, '0);

    // Single request: start two cycles after the pulse, done returns to owner
    tick(4'b0100, 1'b1, 1'b0, '0);
    req_cyc = cyc;
    repeat (8) tick('0, 1'b1, 1'b0, '0);
    check_eq("single_lat", 64'(last_start_cyc - req_cyc), 64'd2);
    check_eq("single_owner", 64'(start_q[$]), 64'd2);
    tick('0, 1'b1, 1'b1, '0);
    repeat (3) tick('0, 1'b1, 1'b0, '0);
    check_eq("single_rdy_at_done", 64'(rdy_at_done[2]), 64'd1);

    // Round-robin from last grant 3
    do_reset();
    start_q.delete();
    tick(4'b1111, 1'b0, 1'b0, '0);
    tick('0, 1'b0, 1'b0, '0);
    for (int c = 0; c < 40; c++) tick('0, 1'b1, m_active && m_age == 3, '0);
    check_eq("rr_count", 64'(start_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < start_q.size(); i++) check_eq("rr_order", 64'(start_q[i]), 64'(i));

    // Watchdog: 100-cycle limit, no done
    d0 = n_done_seen;
    tick(4'b0010, 1'b1, 1'b0, TW'(100));
    for (int c = 0; c < 115; c++) tick('0, 1'b1, 1'b0, TW'(100));
    check_eq("wd_gap", 64'(last_to_cyc - last_start_cyc), 64'd101);
    check_eq("wd_no_done", 64'(n_done_seen - d0), 64'd0);

    // Done and watchdog hit in the same cycle: done wins
    d0 = n_done_seen; t0 = n_to_seen;
    tick(4'b0001, 1'b1, 1'b0, TW'(5));
    for (int c = 0; c < 20; c++) tick('0, 1'b1, m_active && m_age == 5, TW'(5));
    check_eq("coll_done", 64'(n_done_seen - d0), 64'd1);
    check_eq("coll_to", 64'(n_to_seen - t0), 64'd0);

    // Engine backpressure with a repeat request while pending
    d0 = n_start_seen;
    tick(4'b0101, 1'b0, 1'b0, '0);
    tick(4'b0001, 1'b0, 1'b0, '0);
    repeat (5) tick('0, 1'b0, 1'b0, '0);
    check_eq("bp_no_start", 64'(n_start_seen - d0), 64'd0);
    for (int c = 0; c < 20; c++) tick('0, 1'b1, m_active && m_age == 2, '0);
    check_eq("bp_starts", 64'(n_start_seen - d0), 64'd2);

    // Reset while busy: no stray pulses afterwards
    tick(4'b1000, 1'b1, 1'b0, TW'(20));
    repeat (4) tick('0, 1'b1, 1'b0, TW'(20));
    d0 = n_done_seen; t0 = n_to_seen;
    do_reset();
    for (int c = 0; c < 30; c++) tick('0, 1'b1, 1'b1, TW'(20));
    check_eq("rst_no_pulse", 64'((n_done_seen - d0) + (n_to_seen - t0)), 64'd0);

    // Randomized phases
    for (int ph = 0; ph < 4; ph++) begin
      cfg = (ph == 0) ? TW'(0) : (ph == 1) ? TW'(100) : TW'($urandom_range(1, 12));
      for (int c = 0; c < 3000; c++) begin
        rs = N'($urandom) & N'($urandom);
        if (ph == 3 && $urandom_range(0, 19) == 0) cfg = TW'($urandom_range(0, 15));
        if (ph == 3 && $urandom_range(0, 999) == 0) do_reset();
        tick(rs, $urandom_range(0, 3) != 0, $urandom_range(0, (ph == 1) ? 150 : 6) == 0, cfg);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
